uart_cmd_ctrl: RTL and testbench

- Command controller between the UART RX/TX FIFOs and the watch/stopwatch control logic.
- Pops received bytes from the RX FIFO and decodes single-character ASCII commands into one-cycle control pulses.
- Arbitrates the TX FIFO push port between the command echo path and an external multi-byte report requester (time dump). Report packets are never interleaved with echo bytes.

---
 rtl/uart_ctrl_pkg.sv | 53 +++++
 rtl/uart_tx_arb.sv | 88 ++++++++
 rtl/uart_cmd_ctrl.sv | 99 +++++++++
 tb/tb_uart_cmd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART command controller: ASCII command bytes,
// parser/arbiter state encodings and the command decode helper.
package uart_ctrl_pkg;

   localparam logic [7:0] CH_RUN_UP   = 8'h52;
   localparam logic [7:0] CH_RUN_LO   = 8'h72;
   localparam logic [7:0] CH_CLEAR_UP = 8'h43;
   localparam logic [7:0] CH_CLEAR_LO = 8'h63;
   localparam logic [7:0] CH_MODE_UP  = 8'h4D;
   localparam logic [7:0] CH_MODE_LO  = 8'h6D;
   localparam logic [7:0] CH_UP_UP    = 8'h55;
   localparam logic [7:0] CH_UP_LO    = 8'h75;
   localparam logic [7:0] CH_DOWN_UP  = 8'h44;
   localparam logic [7:0] CH_DOWN_LO  = 8'h64;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] ERR_CHAR_DEF = 8'h3F;

   localparam logic [1:0] P_IDLE   = 2'd0;
   localparam logic [1:0] P_DECODE = 2'd1;
   localparam logic [1:0] P_ECHO   = 2'd2;

   localparam logic [1:0] A_FREE      = 2'd0;
   localparam logic [1:0] A_LOCK_ECHO = 2'd1;
   localparam logic [1:0] A_LOCK_REP  = 2'd2;

   typedef struct packed {
      logic run;
      logic clear;
      logic mode;
      logic up;
      logic down;
      logic err;
      logic eol;
   } cmd_t;

   // Line terminators are silently accepted; anything unlisted is an error.
   function automatic cmd_t decode_cmd(input logic [7:0] b);
      cmd_t c;
      c = '0;
      case (b)
         CH_RUN_UP, CH_RUN_LO:     c.run   = 1'b1;
         CH_CLEAR_UP, CH_CLEAR_LO: c.clear = 1'b1;
         CH_MODE_UP, CH_MODE_LO:   c.mode  = 1'b1;
         CH_UP_UP, CH_UP_LO:       c.up    = 1'b1;
         CH_DOWN_UP, CH_DOWN_LO:   c.down  = 1'b1;
         CH_CR, CH_LF:             c.eol   = 1'b1;
         default:                  c.err   = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter for the TX FIFO push port between the echo path and a
// multi-byte report requester; report packets are held locked until their last byte.
module uart_tx_arb
   import uart_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       echo_req,
   input  logic [7:0] echo_data,
   input  logic       rep_req,
   input  logic [7:0] rep_data,
   input  logic       rep_last,
   input  logic       tx_full,
   output logic       tx_push,
   output logic [7:0] tx_data,
   output logic       echo_ack,
   output logic       rep_ack
);

   logic [1:0] state;
   logic       last_rep;
   logic       gnt_echo;
   logic       gnt_rep;
   logic       push_echo;
   logic       push_rep;

   // On a tie the requester that was not served last wins.
   always_comb begin
      gnt_echo = 1'b0;
      gnt_rep  = 1'b0;
      case (state)
         A_FREE: begin
            if (echo_req && rep_req) begin
               gnt_echo = last_rep;
               gnt_rep  = ~last_rep;
            end else begin
               gnt_echo = echo_req;
               gnt_rep  = rep_req;
            end
         end
         A_LOCK_ECHO: gnt_echo = 1'b1;
         A_LOCK_REP:  gnt_rep  = 1'b1;
         default: ;
      endcase
   end

   assign push_echo = en & gnt_echo & echo_req & ~tx_full;
   assign push_rep  = en & gnt_rep & rep_req & ~tx_full;
   assign tx_push   = push_echo | push_rep;
   assign tx_data   = gnt_rep ? rep_data : echo_data;
   assign echo_ack  = push_echo;
   assign rep_ack   = push_rep;

   // A grant blocked by a full FIFO is held in a lock state so it cannot be stolen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= A_FREE;
         last_rep <= 1'b1;
      end else begin
         case (state)
            A_FREE: begin
               if (en && gnt_echo) begin
                  if (push_echo) last_rep <= 1'b0;
                  else           state    <= A_LOCK_ECHO;
               end else if (en && gnt_rep) begin
                  if (push_rep && rep_last) last_rep <= 1'b1;
                  else                      state    <= A_LOCK_REP;
               end
            end
            A_LOCK_ECHO: begin
               if (push_echo) begin
                  state    <= A_FREE;
                  last_rep <= 1'b0;
               end
            end
            A_LOCK_REP: begin
               if (push_rep && rep_last) begin
                  state    <= A_FREE;
                  last_rep <= 1'b1;
               end
            end
            default: state <= A_FREE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: pops RX bytes one at a time, decodes single-character
// commands into one-cycle pulses and echoes them through the shared TX arbiter.
module uart_cmd_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter bit         ECHO_EN  = 1'b1,
   parameter logic [7:0] ERR_CHAR = ERR_CHAR_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx_empty,
   input  logic [7:0] i_rx_data,
   output logic       o_rx_pop,
   input  logic       i_tx_full,
   output logic       o_tx_push,
   output logic [7:0] o_tx_data,
   input  logic       i_rep_req,
   input  logic [7:0] i_rep_data,
   input  logic       i_rep_last,
   output logic       o_rep_ack,
   output logic       o_cmd_run,
   output logic       o_cmd_clear,
   output logic       o_cmd_mode,
   output logic       o_cmd_up,
   output logic       o_cmd_down,
   output logic       o_cmd_err
);

   logic [1:0] state;
   logic [7:0] cmd_reg;
   logic       live;
   logic       in_decode;
   logic       echo_req;
   logic       echo_ack;
   logic [7:0] echo_data;
   cmd_t       cmd;

   // Keeps every output quiet for the first cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   assign cmd       = decode_cmd(cmd_reg);
   assign in_decode = live & (state == P_DECODE);
   assign o_rx_pop  = live & (state == P_IDLE) & ~i_rx_empty;

   assign o_cmd_run   = in_decode & cmd.run;
   assign o_cmd_clear = in_decode & cmd.clear;
   assign o_cmd_mode  = in_decode & cmd.mode;
   assign o_cmd_up    = in_decode & cmd.up;
   assign o_cmd_down  = in_decode & cmd.down;
   assign o_cmd_err   = in_decode & cmd.err;

   assign echo_req  = (state == P_ECHO);
   assign echo_data = cmd.err ? ERR_CHAR : cmd_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= P_IDLE;
         cmd_reg <= '0;
      end else begin
         case (state)
            P_IDLE: begin
               if (o_rx_pop) begin
                  cmd_reg <= i_rx_data;
                  state   <= P_DECODE;
               end
            end
            P_DECODE: begin
               if (cmd.eol)                state <= P_IDLE;
               else if (cmd.err || ECHO_EN) state <= P_ECHO;
               else                        state <= P_IDLE;
            end
            P_ECHO: begin
               if (echo_ack) state <= P_IDLE;
            end
            default: state <= P_IDLE;
         endcase
      end
   end

   uart_tx_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (live),
      .echo_req  (echo_req),
      .echo_data (echo_data),
      .rep_req   (i_rep_req),
      .rep_data  (i_rep_data),
      .rep_last  (i_rep_last),
      .tx_full   (i_tx_full),
      .tx_push   (o_tx_push),
      .tx_data   (o_tx_data),
      .echo_ack  (echo_ack),
      .rep_ack   (o_rep_ack)
   );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: small RX FIFO and report requester models,
// per-cycle expected output vectors computed by hand for each scenario.
module tb_uart_cmd_ctrl;

   localparam logic [8:0] E_POP  = 9'h100;
   localparam logic [8:0] E_PUSH = 9'h080;
   localparam logic [8:0] E_ACK  = 9'h040;
   localparam logic [8:0] E_RUN  = 9'h020;
   localparam logic [8:0] E_CLR  = 9'h010;
   localparam logic [8:0] E_MODE = 9'h008;
   localparam logic [8:0] E_UP   = 9'h004;
   localparam logic [8:0] E_DN   = 9'h002;
   localparam logic [8:0] E_ERR  = 9'h001;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rx_empty;
   logic [7:0] i_rx_data;
   logic       o_rx_pop;
   logic       i_tx_full;
   logic       o_tx_push;
   logic [7:0] o_tx_data;
   logic       i_rep_req;
   logic [7:0] i_rep_data;
   logic       i_rep_last;
   logic       o_rep_ack;
   logic       o_cmd_run;
   logic       o_cmd_clear;
   logic       o_cmd_mode;
   logic       o_cmd_up;
   logic       o_cmd_down;
   logic       o_cmd_err;

   logic [7:0] rx_q[$];
   logic [8:0] rep_q[$];
   logic       rep_hold;
   int         n_tests = 0;
   int         n_fail  = 0;

   wire [8:0] outs = {o_rx_pop, o_tx_push, o_rep_ack, o_cmd_run, o_cmd_clear,
                      o_cmd_mode, o_cmd_up, o_cmd_down, o_cmd_err};

   always #5 clk = ~clk;

   uart_cmd_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_empty  (i_rx_empty),
      .i_rx_data   (i_rx_data),
      .o_rx_pop    (o_rx_pop),
      .i_tx_full   (i_tx_full),
      .o_tx_push   (o_tx_push),
      .o_tx_data   (o_tx_data),
      .i_rep_req   (i_rep_req),
      .i_rep_data  (i_rep_data),
      .i_rep_last  (i_rep_last),
      .o_rep_ack   (o_rep_ack),
      .o_cmd_run   (o_cmd_run),
      .o_cmd_clear (o_cmd_clear),
      .o_cmd_mode  (o_cmd_mode),
      .o_cmd_up    (o_cmd_up),
      .o_cmd_down  (o_cmd_down),
      .o_cmd_err   (o_cmd_err)
   );

   task automatic refresh();
      i_rx_empty = (rx_q.size() == 0);
      i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      i_rep_req  = !rep_hold && (rep_q.size() != 0);
      i_rep_data = (rep_q.size() != 0) ? rep_q[0][7:0] : 8'h00;
      i_rep_last = (rep_q.size() != 0) ? rep_q[0][8] : 1'b0;
   endtask

   // Called right after a negedge check; the FIFO models consume what the DUT took.
   task automatic next_cycle();
      logic pop_now;
      logic ack_now;
      pop_now = o_rx_pop;
      ack_now = o_rep_ack;
      @(posedge clk);
      #1;
      if (pop_now === 1'b1 && rx_q.size() != 0) void'(rx_q.pop_front());
      if (ack_now === 1'b1 && rep_q.size() != 0) void'(rep_q.pop_front());
      refresh();
   endtask

   task automatic test_reset();
      logic [8:0] eo [7];
      logic [7:0] ed [7];
      eo = '{9'h0, 9'h0, 9'h0, E_POP, E_UP, E_PUSH, 9'h0};
      ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h75, 8'h00};
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         if (i == 0) begin rx_q.push_back(8'h75); refresh(); end
         if (i == 2) rst = 1'b0;
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL reset c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL reset c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   task automatic test_run();
      logic [8:0] eo [4];
      logic [7:0] ed [4];
      eo = '{E_POP, E_RUN, E_PUSH, 9'h0};
      ed = '{8'h00, 8'h00, 8'h72, 8'h00};
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (i == 0) begin rx_q.push_back(8'h72); refresh(); end
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL run c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL run c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   task automatic test_err_crlf();
      logic [8:0] eo [6];
      logic [7:0] ed [6];
      eo = '{E_POP, E_ERR, E_PUSH, E_POP, 9'h0, 9'h0};
      ed = '{8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         if (i == 0) begin
            rx_q.push_back(8'h5A);
            rx_q.push_back(8'h0D);
            refresh();
         end
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL err_crlf c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL err_crlf c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   task automatic test_report_lock();
      logic [8:0] eo [5];
      logic [7:0] ed [5];
      eo = '{E_PUSH | E_ACK, E_POP | E_PUSH | E_ACK, E_CLR | E_PUSH | E_ACK, E_PUSH, 9'h0};
      ed = '{8'h31, 8'h32, 8'h33, 8'h63, 8'h00};
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         if (i == 0) begin
            rep_q.push_back({1'b0, 8'h31});
            rep_q.push_back({1'b0, 8'h32});
            rep_q.push_back({1'b1, 8'h33});
            refresh();
         end
         if (i == 1) begin rx_q.push_back(8'h63); refresh(); end
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL report_lock c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL report_lock c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   task automatic test_full();
      logic [8:0] eo [17];
      logic [7:0] ed [17];
      eo = '{E_POP, E_MODE, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0,
             E_PUSH, E_POP, E_CLR, E_PUSH, 9'h0};
      ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h4D, 8'h00, 8'h00, 8'h63, 8'h00};
      for (int i = 0; i < 17; i++) begin
         next_cycle();
         if (i == 0) begin
            i_tx_full = 1'b1;
            rx_q.push_back(8'h4D);
            rx_q.push_back(8'h63);
            refresh();
         end
         if (i == 12) i_tx_full = 1'b0;
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL full c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL full c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] eo [8];
      logic [7:0] ed [8];
      eo = '{E_POP, 9'h0, 9'h0, 9'h0, E_POP, E_RUN, E_PUSH, 9'h0};
      ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h72, 8'h00};
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         if (i == 0) begin
            rx_q.push_back(8'h6D);
            rx_q.push_back(8'h72);
            refresh();
         end
         if (i == 1) rst = 1'b1;
         if (i == 3) rst = 1'b0;
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL reset_mid c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL reset_mid c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   // Fresh reset so the first tie goes to echo, then alternating winners.
   task automatic test_back_to_back();
      logic [8:0] eo [11];
      logic [7:0] ed [11];
      eo = '{9'h0, 9'h0, E_POP, E_DN, E_PUSH, E_POP, E_UP, E_PUSH | E_ACK, E_PUSH,
             E_PUSH | E_ACK, 9'h0};
      ed = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h41, 8'h55, 8'h42, 8'h00};
      for (int i = 0; i < 11; i++) begin
         next_cycle();
         if (i == 0) begin
            rst      = 1'b1;
            rep_hold = 1'b1;
            rx_q.push_back(8'h64);
            rx_q.push_back(8'h55);
            rep_q.push_back({1'b1, 8'h41});
            rep_q.push_back({1'b1, 8'h42});
            refresh();
         end
         if (i == 1) rst = 1'b0;
         if (i == 4) begin rep_hold = 1'b0; refresh(); end
         if (i == 5) begin rep_hold = 1'b1; refresh(); end
         if (i == 7) begin rep_hold = 1'b0; refresh(); end
         @(negedge clk);
         n_tests++;
         if (outs !== eo[i]) begin
            n_fail++;
            $display("[TB] FAIL tie c%0d outs got %b want %b", i, outs, eo[i]);
         end
         if (eo[i][7]) begin
            n_tests++;
            if (o_tx_data !== ed[i]) begin
               n_fail++;
               $display("[TB] FAIL tie c%0d data got %h want %h", i, o_tx_data, ed[i]);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      i_tx_full = 1'b0;
      rep_hold  = 1'b0;
      refresh();
      test_reset();
      test_run();
      test_err_crlf();
      test_report_lock();
      test_full();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
